zynq_rd_collector: RTL

ZYNQ_RD_COLLECTOR -- requirements
Module: zynq_rd_collector

---
 rtl/zynq_rd_collector_pkg.sv | 15 +
 rtl/zynq_rd_collector_rd_timeout_ctr.sv | 27 ++
 rtl/zynq_rd_collector.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/zynq_rd_collector_pkg.sv
// Shared types and constants for the digitizer read collector.
package zynq_rd_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int CHAN_DEF    = 8;
  localparam int TIMEOUT_DEF = 4096;
  localparam int SAMPLE_W    = 12;

endpackage

// File: rtl/zynq_rd_collector_rd_timeout_ctr.sv
// Idle-cycle counter: clr reloads zero, inc advances; expire flags the LIMIT-th
// consecutive idle cycle combinationally so the FSM can leave on that same edge.
module rd_timeout_ctr #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = inc && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/zynq_rd_collector.sv
// Reads one event (CHAN channels x sample_num words) from the digitizer and
// forwards each word one cycle after capture, with sticky error reporting.
module zynq_rd_collector
  import zynq_rd_collector_pkg::*;
#(
  parameter int CHAN    = CHAN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                CK50,
  input  logic                RST,
  input  logic                start,
  input  logic [11:0]         sample_num,
  output logic                EOS,
  input  logic                RD_EN,
  input  logic [15:0]         DIN,
  output logic                evt_valid,
  output logic [SAMPLE_W-1:0] evt_data,
  output logic [2:0]          evt_chan,
  output logic                evt_first,
  output logic                evt_last,
  output logic                busy,
  output logic                done,
  output logic [15:0]         evt_count,
  output logic                err_timeout,
  output logic                err_format,
  output logic                err_extra
);

  state_t      state, next_state;
  logic [11:0] smp;
  logic [11:0] word_cnt;
  logic [2:0]  chan_idx;
  logic        word_last;
  logic        accept, capture, end_ok, end_to;
  logic        cnt_inc, cnt_clr, expire;

  assign word_last = (word_cnt == smp - 12'd1);
  assign EOS       = (state == REQ);
  assign busy      = (state != IDLE);
  // Every non-IDLE transition except a timeout exit coincides with a capture,
  // so clearing on IDLE and on capture covers every state entry.
  assign cnt_clr   = (state == IDLE) || capture;

  rd_timeout_ctr #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk   (CK50),
    .rst   (RST),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .expire(expire)
  );

  always_ff @(posedge CK50) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    end_ok     = 1'b0;
    end_to     = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (sample_num != 12'd0)) begin
          accept     = 1'b1;
          next_state = REQ;
        end
      end
      REQ, DATA: begin
        if (RD_EN) begin
          capture    = 1'b1;
          next_state = (word_last && (chan_idx == 3'd0)) ? DRAIN : DATA;
        end else begin
          cnt_inc = 1'b1;
          if (expire) begin
            end_to     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      DRAIN: begin
        if (RD_EN) begin
          cnt_inc = 1'b1;
          if (expire) begin
            end_to     = 1'b1;
            next_state = IDLE;
          end
        end else begin
          end_ok     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CK50) begin
    if (RST) begin
      smp         <= '0;
      word_cnt    <= '0;
      chan_idx    <= '0;
      evt_valid   <= 1'b0;
      evt_data    <= '0;
      evt_chan    <= '0;
      evt_first   <= 1'b0;
      evt_last    <= 1'b0;
      done        <= 1'b0;
      evt_count   <= '0;
      err_timeout <= 1'b0;
      err_format  <= 1'b0;
      err_extra   <= 1'b0;
    end else begin
      evt_valid <= capture;
      done      <= end_ok || end_to;
      if (accept) begin
        smp         <= sample_num;
        word_cnt    <= '0;
        chan_idx    <= 3'(CHAN - 1);
        err_timeout <= 1'b0;
        err_format  <= 1'b0;
        err_extra   <= 1'b0;
      end
      if (capture) begin
        evt_data  <= DIN[15:4];
        evt_chan  <= chan_idx;
        evt_first <= (word_cnt == 12'd0);
        evt_last  <= word_last;
        if (DIN[3:0] != 4'd0) begin
          err_format <= 1'b1;
        end
        if (word_last) begin
          word_cnt <= '0;
          if (chan_idx != 3'd0) begin
            chan_idx <= chan_idx - 3'd1;
          end
        end else begin
          word_cnt <= word_cnt + 12'd1;
        end
      end
      if ((state == DRAIN) && RD_EN) begin
        err_extra <= 1'b1;
      end
      if (end_to) begin
        err_timeout <= 1'b1;
      end
      if (end_ok) begin
        evt_count <= evt_count + 16'd1;
      end
    end
  end

endmodule
